stage_sequencer: RTL and testbench
==================================

# stage_sequencer

Multi-cycle control FSM for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, and handshakes with instruction and data memory. It drives the register bank's write strobes (`save_to_reg`, `save_from_memory`), the PC and IR enables, and a retired-instruction counter. It sits beside the datapath and is the only source of register-bank write enables.

## Interface
- `MEM_TIMEOUT`, default 15: consecutive unanswered request edges before a fault is raised; 0 disables the timeout.
- `stage_clk` in 1: stage clock.
- `reset` in 1: reset, asynchronous, active-high.
- `opcode` in 7: `instr[6:0]` from the IR; valid from DECODE onward.
- `imem_ready` in 1: instruction memory data valid.
- `dmem_ready` in 1: data memory access done.
- `imem_req` out 1: fetch request.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: data write (store).
- `ir_en` out 1: latch the instruction into the IR.
- `pc_en` out 1: update the PC (end of instruction).
- `save_to_reg` out 1: register-bank write from the ALU.
- `save_from_memory` out 1: register-bank write from memory.
- `halt` out 1: stopped on SYSTEM.
- `fault` out 1: stopped on an error.
- `fault_cause` out 2: 0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout.
- `retired_count` out 32: instructions completed.

## Operation
- **States:** RESET_WAIT, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT, FAULT. RESET_WAIT is the reset state.
- **Opcode classes:**
  - LOAD 0000011, STORE 0100011, BRANCH 1100011, SYSTEM 1110011.
  - ALU group: OP 0110011, OP_IMM 0010011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
  - Anything else is ILLEGAL.
- **RESET_WAIT:** all outputs 0; go to FETCH on the next edge.
- **FETCH:** `imem_req`=1.
  - On `imem_ready`: `ir_en`=1 (combinational, same cycle), go to DECODE.
  - On timeout: go to FAULT with cause 2.
- **DECODE:** register the opcode class.
  - ILLEGAL: go to FAULT with cause 1.
  - SYSTEM: go to HALT.
  - Otherwise: go to EXECUTE.
- **EXECUTE:**
  - LOAD or STORE: go to MEMORY.
  - BRANCH: `pc_en`=1, go to FETCH.
  - Otherwise: go to WRITEBACK.
- **MEMORY:** `dmem_req`=1; `dmem_we`=1 for STORE only.
  - On `dmem_ready` with STORE: `pc_en`=1, go to FETCH.
  - On `dmem_ready` with LOAD: go to WRITEBACK.
  - On timeout: go to FAULT with cause 3.
- **WRITEBACK:** one cycle, `pc_en`=1, go to FETCH.
  - LOAD: `save_from_memory`=1.
  - Otherwise: `save_to_reg`=1.
  - Never both strobes at once.
- **HALT / FAULT:** absorbing; only `reset` exits. All request, enable and strobe outputs are 0.
- **Retirement:** `retired_count` increments on every edge where `pc_en`=1; wraps modulo 2^32.
- **Output decode:**
  - All outputs are decoded from the registered state and class, except `ir_en` and the STORE `pc_en` in MEMORY, which are also qualified by the ready input.
  - `halt`, `fault` and `fault_cause` hold until reset.

## Timing
- **Reset values:** on assertion, all outputs go to 0 immediately (asynchronous), `retired_count`=0, `fault_cause`=0. The first FETCH cycle is the second edge after reset deassertion.
- **Latency with zero-wait memory:**
  - ALU op: FETCH→DECODE→EXECUTE→WRITEBACK, 4 cycles.
  - BRANCH: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
- **Timeout counter:**
  - Width `$clog2(MEM_TIMEOUT+1)`; cleared on entry to FETCH or MEMORY.
  - Increments on each edge in FETCH or MEMORY with ready=0.
  - Faults when the count reaches `MEM_TIMEOUT`.
  - Ready sampled on the same edge as the final count takes priority: no fault.
- **Handshakes:**
  - Requests stay high until ready; ready outside FETCH or MEMORY is ignored.
  - Memory must not assert ready while the request is low.
- **Register-bank write:** the bank captures on the edge that closes the WRITEBACK cycle, the same edge as the PC update.
- **Reset mid-instruction:** the instruction is abandoned, no strobe is emitted, and the count is not incremented.

## Structure
- **Package `cpu_pkg`:**
  - Opcode localparams.
  - State enum.
  - Class enum (ALU, LOAD, STORE, BRANCH, SYSTEM, ILLEGAL).
  - `fault_cause` encodings.
- **Sub-module `opcode_classifier`:** combinational, 7-bit opcode to class.
- **Top:** FSM, timeout counter and retire counter.

## Test plan
- **ADDI (0010011), `imem_ready` on the 2nd FETCH cycle:** DECODE, EXECUTE, then one WRITEBACK cycle with `save_to_reg`=1 and `pc_en`=1; `retired_count`=1 after that edge.
- **LOAD, `dmem_ready` on the 3rd MEMORY cycle:** `dmem_we`=0; then one WRITEBACK cycle with `save_from_memory`=1 and `save_to_reg`=0.
- **STORE with immediate `dmem_ready`:** `dmem_we`=1; `pc_en`=1 in MEMORY; no save strobe ever; back to FETCH; count +1.
- **Opcode 0000000:** FAULT with `fault_cause`=1; no strobes; stays through 20 cycles; SYSTEM opcode gives `halt`=1 the same way.
- **`MEM_TIMEOUT`=4, `dmem_ready` held low:** FAULT with cause 3 after 4 MEMORY edges. Rerun with ready on the 4th edge: no fault, WRITEBACK follows.
- **Reset asserted mid-MEMORY after 3 retirements:** outputs 0 immediately; `retired_count`=0; RESET_WAIT then FETCH after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the RV32I multi-cycle control path.
//   - RV32I major opcode values (instr[6:0])
//   - state_t      : sequencer FSM states
//   - op_class_t   : decoded opcode class
//   - fault_cause_t: encoding reported on fault_cause
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package cpu_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    ST_RESET_WAIT,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEMORY,
    ST_WRITEBACK,
    ST_HALT,
    ST_FAULT
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_SYSTEM,
    CLS_ILLEGAL
  } op_class_t;

  typedef enum logic [1:0] {
    CAUSE_NONE         = 2'd0,
    CAUSE_ILLEGAL      = 2'd1,
    CAUSE_IMEM_TIMEOUT = 2'd2,
    CAUSE_DMEM_TIMEOUT = 2'd3
  } fault_cause_t;

endpackage

// File: rtl/stage_sequencer_if.sv
// ---------------------------------------------------------------------------
// stage_sequencer_if
// Request/ready handshake between the stage sequencer and the instruction
// and data memories.
//   imem_req   : fetch request            (sequencer -> imem)
//   imem_ready : instruction data valid   (imem -> sequencer)
//   dmem_req   : data access request      (sequencer -> dmem)
//   dmem_we    : data access is a store   (sequencer -> dmem)
//   dmem_ready : data access done         (dmem -> sequencer)
// master = sequencer side, slave = memory side.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface stage_sequencer_if;

  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ready,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ready,
    output dmem_ready
  );

endinterface

// File: rtl/opcode_classifier.sv
// ---------------------------------------------------------------------------
// opcode_classifier
// Purely combinational map from the 7-bit RV32I major opcode to its
// control class. Unknown encodings map to CLS_ILLEGAL.
//   opcode   in  7 : instr[6:0]
//   op_class out   : decoded class
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module opcode_classifier
  import cpu_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class
);

  always_comb begin
    case (opcode)
      OPC_LOAD:   op_class = CLS_LOAD;
      OPC_STORE:  op_class = CLS_STORE;
      OPC_BRANCH: op_class = CLS_BRANCH;
      OPC_SYSTEM: op_class = CLS_SYSTEM;
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR:
                  op_class = CLS_ALU;
      default:    op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/stage_sequencer.sv
// ---------------------------------------------------------------------------
// stage_sequencer
// Multi-cycle control FSM for the RV32I core: steps each instruction through
// FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, handshakes with instruction
// and data memory, and is the only source of register-bank write enables.
//
// Parameters
//   MEM_TIMEOUT : consecutive unanswered request edges before a fault
//                 (0 disables the timeout)
// Ports
//   stage_clk        in  : stage clock
//   reset            in  : asynchronous, active-high reset
//   opcode           in 7: instr[6:0] from the IR, valid from DECODE onward
//   mem              if  : imem/dmem request/ready handshake (master)
//   ir_en            out : latch the fetched instruction into the IR
//   pc_en            out : update the PC (end of instruction)
//   save_to_reg      out : register-bank write from the ALU
//   save_from_memory out : register-bank write from memory
//   halt             out : stopped on SYSTEM
//   fault            out : stopped on an error
//   fault_cause      out 2: 0 none, 1 illegal, 2 imem timeout, 3 dmem timeout
//   retired_count    out 32: instructions completed (wraps)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module stage_sequencer
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                stage_clk,
  input  logic                reset,
  input  logic [6:0]          opcode,
  stage_sequencer_if.master   mem,
  output logic                ir_en,
  output logic                pc_en,
  output logic                save_to_reg,
  output logic                save_from_memory,
  output logic                halt,
  output logic                fault,
  output logic [1:0]          fault_cause,
  output logic [31:0]         retired_count
);

  // A zero timeout still needs a legal one-bit counter.
  localparam int TMO_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t       state;
  state_t       state_next;
  op_class_t    dec_class;
  op_class_t    cls_q;
  fault_cause_t cause_q;
  fault_cause_t cause_next;
  logic [TMO_W-1:0] tmo_cnt;
  logic         mem_wait;
  logic         tmo_expired;

  opcode_classifier u_classifier (
    .opcode   (opcode),
    .op_class (dec_class)
  );

  // Waiting on an unanswered request; the edge that would bring the counter
  // to MEM_TIMEOUT is the faulting edge, unless ready arrives on it.
  always_comb begin
    mem_wait = 1'b0;
    if (state == ST_FETCH)
      mem_wait = !mem.imem_ready;
    else if (state == ST_MEMORY)
      mem_wait = !mem.dmem_ready;
    tmo_expired = (MEM_TIMEOUT != 0) && mem_wait && (tmo_cnt == TMO_LAST);
  end

  // State register plus the class and fault cause that travel with it.
  always_ff @(posedge stage_clk or posedge reset) begin
    if (reset) begin
      state   <= ST_RESET_WAIT;
      cls_q   <= CLS_ALU;
      cause_q <= CAUSE_NONE;
    end else begin
      state   <= state_next;
      cause_q <= cause_next;
      if (state == ST_DECODE)
        cls_q <= dec_class;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    cause_next = cause_q;
    case (state)
      ST_RESET_WAIT: state_next = ST_FETCH;
      ST_FETCH: begin
        if (mem.imem_ready) begin
          state_next = ST_DECODE;
        end else if (tmo_expired) begin
          state_next = ST_FAULT;
          cause_next = CAUSE_IMEM_TIMEOUT;
        end
      end
      ST_DECODE: begin
        case (dec_class)
          CLS_ILLEGAL: begin
            state_next = ST_FAULT;
            cause_next = CAUSE_ILLEGAL;
          end
          CLS_SYSTEM: state_next = ST_HALT;
          default:    state_next = ST_EXECUTE;
        endcase
      end
      ST_EXECUTE: begin
        case (cls_q)
          CLS_LOAD, CLS_STORE: state_next = ST_MEMORY;
          CLS_BRANCH:          state_next = ST_FETCH;
          default:             state_next = ST_WRITEBACK;
        endcase
      end
      ST_MEMORY: begin
        if (mem.dmem_ready) begin
          state_next = (cls_q == CLS_STORE) ? ST_FETCH : ST_WRITEBACK;
        end else if (tmo_expired) begin
          state_next = ST_FAULT;
          cause_next = CAUSE_DMEM_TIMEOUT;
        end
      end
      ST_WRITEBACK: state_next = ST_FETCH;
      ST_HALT:      state_next = ST_HALT;
      ST_FAULT:     state_next = ST_FAULT;
      default:      state_next = ST_RESET_WAIT;
    endcase
  end

  // Output decode. Only ir_en and the store-completion pc_en look at ready.
  always_comb begin
    mem.imem_req     = 1'b0;
    mem.dmem_req     = 1'b0;
    mem.dmem_we      = 1'b0;
    ir_en            = 1'b0;
    pc_en            = 1'b0;
    save_to_reg      = 1'b0;
    save_from_memory = 1'b0;
    halt             = 1'b0;
    fault            = 1'b0;
    case (state)
      ST_FETCH: begin
        mem.imem_req = 1'b1;
        ir_en        = mem.imem_ready;
      end
      ST_EXECUTE: pc_en = (cls_q == CLS_BRANCH);
      ST_MEMORY: begin
        mem.dmem_req = 1'b1;
        mem.dmem_we  = (cls_q == CLS_STORE);
        pc_en        = mem.dmem_ready && (cls_q == CLS_STORE);
      end
      ST_WRITEBACK: begin
        pc_en = 1'b1;
        if (cls_q == CLS_LOAD)
          save_from_memory = 1'b1;
        else
          save_to_reg = 1'b1;
      end
      ST_HALT:  halt  = 1'b1;
      ST_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  assign fault_cause = cause_q;

  // Timeout counter restarts whenever a new state is entered.
  always_ff @(posedge stage_clk or posedge reset) begin
    if (reset)
      tmo_cnt <= '0;
    else if (state_next != state)
      tmo_cnt <= '0;
    else if (mem_wait)
      tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  // Retire counter: one per PC update.
  always_ff @(posedge stage_clk or posedge reset) begin
    if (reset)
      retired_count <= 32'd0;
    else if (pc_en)
      retired_count <= retired_count + 32'd1;
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// ---------------------------------------------------------------------------
// tb_stage_sequencer
// Self-checking bench for stage_sequencer (MEM_TIMEOUT = 4). A memory
// responder answers each request after a chosen number of wait cycles and
// every instruction is compared against per-class expectations (cycle count,
// request lengths, strobes, retire count).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stage_sequencer;

  localparam int TMO = 4;

  logic        stage_clk;
  logic        reset;
  logic [6:0]  opcode;
  logic        ir_en;
  logic        pc_en;
  logic        save_to_reg;
  logic        save_from_memory;
  logic        halt;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] retired_count;

  int checks;
  int failures;
  logic [31:0] exp_retired;

  logic [6:0] alu_ops [6] = '{7'b0110011, 7'b0010011, 7'b0110111,
                              7'b0010111, 7'b1101111, 7'b1100111};

  stage_sequencer_if mif ();

  stage_sequencer #(.MEM_TIMEOUT(TMO)) dut (
    .stage_clk        (stage_clk),
    .reset            (reset),
    .opcode           (opcode),
    .mem              (mif.master),
    .ir_en            (ir_en),
    .pc_en            (pc_en),
    .save_to_reg      (save_to_reg),
    .save_from_memory (save_from_memory),
    .halt             (halt),
    .fault            (fault),
    .fault_cause      (fault_cause),
    .retired_count    (retired_count)
  );

  initial stage_clk = 1'b0;
  always #5 stage_clk = ~stage_clk;

  // Reference classification straight from the RV32I opcode map.
  function automatic bit is_legal(logic [6:0] op);
    return op inside {7'b0000011, 7'b0100011, 7'b1100011, 7'b1110011,
                      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                      7'b1101111, 7'b1100111};
  endfunction

  task automatic reset_dut();
    reset = 1'b1;
    mif.imem_ready = 1'b0;
    mif.dmem_ready = 1'b0;
    opcode = 7'd0;
    repeat (2) @(posedge stage_clk);
    @(negedge stage_clk);
    reset = 1'b0;
    @(posedge stage_clk);
    #1;
    exp_retired = 32'd0;
  endtask

  // Drives one instruction from FETCH to its PC update with wi imem wait
  // cycles and wd dmem wait cycles, then compares against the expected shape.
  task automatic run_instr(input logic [6:0] op, input int wi, input int wd);
    int icnt, dcnt, cyc, n_s2r, n_sfm, n_both, n_we, n_dreq, n_ireq, n_ir, exp_cyc;
    bit done, is_ld, is_st, is_br, is_alu, last_s2r, last_sfm;
    is_ld = (op == 7'b0000011);
    is_st = (op == 7'b0100011);
    is_br = (op == 7'b1100011);
    is_alu = is_legal(op) && !is_ld && !is_st && !is_br && (op != 7'b1110011);
    icnt = 0; dcnt = 0; cyc = 0; n_s2r = 0; n_sfm = 0; n_both = 0;
    n_we = 0; n_dreq = 0; n_ireq = 0; n_ir = 0; done = 0;
    last_s2r = 0; last_sfm = 0;
    while (!done && cyc < 100) begin
      @(negedge stage_clk);
      opcode = op;
      #1;
      mif.imem_ready = mif.imem_req && (icnt == wi);
      if (mif.imem_req) icnt++;
      mif.dmem_ready = mif.dmem_req && (dcnt == wd);
      if (mif.dmem_req) dcnt++;
      #1;
      cyc++;
      if (mif.imem_req) n_ireq++;
      if (mif.dmem_req) n_dreq++;
      if (mif.dmem_req && mif.dmem_we) n_we++;
      if (ir_en) n_ir++;
      if (save_to_reg) n_s2r++;
      if (save_from_memory) n_sfm++;
      if (save_to_reg && save_from_memory) n_both++;
      if (pc_en) begin
        done = 1;
        last_s2r = save_to_reg;
        last_sfm = save_from_memory;
      end
    end
    @(posedge stage_clk);
    #1;
    mif.imem_ready = 1'b0;
    mif.dmem_ready = 1'b0;
    exp_retired = exp_retired + 32'd1;
    exp_cyc = wi + 3 + ((is_ld || is_st) ? wd + 1 : 0) + ((is_alu || is_ld) ? 1 : 0);

    checks++;
    if (!done) begin
      failures++;
      $display("[TB] FAIL instr_timeout op=%b: no pc_en within %0d cycles", op, cyc);
    end
    checks++;
    if (cyc !== exp_cyc) begin
      failures++;
      $display("[TB] FAIL latency op=%b wi=%0d wd=%0d: got %0d cycles, expected %0d", op, wi, wd, cyc, exp_cyc);
    end
    checks++;
    if (n_ireq !== wi + 1 || n_ir !== 1) begin
      failures++;
      $display("[TB] FAIL fetch op=%b: imem_req cycles %0d ir_en %0d, expected %0d and 1", op, n_ireq, n_ir, wi + 1);
    end
    checks++;
    if (n_dreq !== ((is_ld || is_st) ? wd + 1 : 0) || n_we !== (is_st ? wd + 1 : 0)) begin
      failures++;
      $display("[TB] FAIL dmem op=%b: dmem_req %0d dmem_we %0d, expected %0d and %0d", op, n_dreq, n_we,
               (is_ld || is_st) ? wd + 1 : 0, is_st ? wd + 1 : 0);
    end
    checks++;
    if (n_s2r !== (is_alu ? 1 : 0) || n_sfm !== (is_ld ? 1 : 0) || n_both !== 0) begin
      failures++;
      $display("[TB] FAIL strobes op=%b: save_to_reg %0d save_from_memory %0d both %0d, expected %0d %0d 0",
               op, n_s2r, n_sfm, n_both, is_alu ? 1 : 0, is_ld ? 1 : 0);
    end
    checks++;
    if (last_s2r !== is_alu || last_sfm !== is_ld) begin
      failures++;
      $display("[TB] FAIL strobe_with_pc op=%b: on pc_en cycle s2r=%0d sfm=%0d, expected %0d %0d",
               op, last_s2r, last_sfm, is_alu, is_ld);
    end
    checks++;
    if (retired_count !== exp_retired) begin
      failures++;
      $display("[TB] FAIL retired op=%b: got %0d, expected %0d", op, retired_count, exp_retired);
    end
  endtask

  // Walks a LOAD/STORE from FETCH into its first MEMORY cycle.
  task automatic goto_memory(input logic [6:0] op);
    @(negedge stage_clk);
    opcode = op;
    mif.imem_ready = 1'b1;
    @(posedge stage_clk);
    #1;
    mif.imem_ready = 1'b0;
    repeat (2) @(posedge stage_clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    opcode = 7'd0;
    mif.imem_ready = 1'b0;
    mif.dmem_ready = 1'b0;
    #3;
    checks++;
    if ({mif.imem_req, mif.dmem_req, mif.dmem_we, ir_en, pc_en, save_to_reg, save_from_memory,
         halt, fault, fault_cause, retired_count} !== 43'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: some output nonzero during reset, retired=%0d", retired_count);
    end
    @(negedge stage_clk);
    @(negedge stage_clk);
    reset = 1'b0;
    #1;
    checks++;
    if (mif.imem_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_wait: imem_req=%b, expected 0", mif.imem_req);
    end
    @(posedge stage_clk);
    #1;
    checks++;
    if (mif.imem_req !== 1'b1 || retired_count !== 32'd0) begin
      failures++;
      $display("[TB] FAIL first_fetch: imem_req=%b retired=%0d, expected 1 and 0", mif.imem_req, retired_count);
    end
    exp_retired = 32'd0;
  endtask

  task automatic test_directed();
    reset_dut();
    run_instr(7'b0010011, 1, 0);
    run_instr(7'b0000011, 0, 2);
    run_instr(7'b0100011, 0, 0);
    run_instr(7'b1100011, 0, 0);
    run_instr(7'b0000011, 0, TMO - 1);
    run_instr(7'b0110111, TMO - 1, 0);
  endtask

  task automatic test_random();
    logic [6:0] op;
    reset_dut();
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: op = alu_ops[$urandom_range(0, 5)];
        1: op = 7'b0000011;
        2: op = 7'b0100011;
        default: op = 7'b1100011;
      endcase
      run_instr(op, $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1));
    end
  endtask

  // Reaches HALT or FAULT from DECODE and verifies the state is absorbing.
  task automatic check_stop(input logic [6:0] op, input logic exp_halt, input logic exp_fault,
                            input logic [1:0] exp_cause, input string name);
    reset_dut();
    @(negedge stage_clk);
    opcode = op;
    mif.imem_ready = 1'b1;
    @(posedge stage_clk);
    #1;
    mif.imem_ready = 1'b0;
    @(posedge stage_clk);
    #1;
    for (int c = 0; c < 20; c++) begin
      @(negedge stage_clk);
      checks++;
      if ({mif.imem_req, mif.dmem_req, mif.dmem_we, ir_en, pc_en, save_to_reg, save_from_memory,
           halt, fault, fault_cause} !== {7'd0, exp_halt, exp_fault, exp_cause} || retired_count !== 32'd0) begin
        failures++;
        $display("[TB] FAIL %s cycle %0d: halt=%b fault=%b cause=%0d pc_en=%b s2r=%b sfm=%b req=%b retired=%0d, expected halt=%b fault=%b cause=%0d, rest 0",
                 name, c, halt, fault, fault_cause, pc_en, save_to_reg, save_from_memory, mif.imem_req,
                 retired_count, exp_halt, exp_fault, exp_cause);
      end
    end
  endtask

  task automatic test_stop_states();
    logic [6:0] op;
    check_stop(7'b0000000, 1'b0, 1'b1, 2'd1, "illegal_zero");
    do op = 7'($urandom_range(0, 127)); while (is_legal(op));
    check_stop(op, 1'b0, 1'b1, 2'd1, "illegal_random");
    check_stop(7'b1110011, 1'b1, 1'b0, 2'd0, "system_halt");
  endtask

  task automatic test_timeout();
    reset_dut();
    opcode = 7'b0010011;
    for (int e = 1; e <= TMO; e++) begin
      @(posedge stage_clk);
      #1;
      checks++;
      if (e < TMO ? (fault !== 1'b0 || mif.imem_req !== 1'b1) : (fault !== 1'b1 || fault_cause !== 2'd2)) begin
        failures++;
        $display("[TB] FAIL imem_timeout edge %0d: fault=%b cause=%0d imem_req=%b", e, fault, fault_cause, mif.imem_req);
      end
    end
    reset_dut();
    goto_memory(7'b0000011);
    for (int e = 1; e <= TMO; e++) begin
      @(posedge stage_clk);
      #1;
      checks++;
      if (e < TMO ? (fault !== 1'b0 || mif.dmem_req !== 1'b1) : (fault !== 1'b1 || fault_cause !== 2'd3)) begin
        failures++;
        $display("[TB] FAIL dmem_timeout edge %0d: fault=%b cause=%0d dmem_req=%b", e, fault, fault_cause, mif.dmem_req);
      end
    end
    checks++;
    if (save_from_memory !== 1'b0 || pc_en !== 1'b0 || mif.dmem_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL dmem_timeout_quiet: sfm=%b pc_en=%b dmem_req=%b, expected 0", save_from_memory, pc_en, mif.dmem_req);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    for (int n = 0; n < 3; n++)
      run_instr(alu_ops[$urandom_range(0, 5)], $urandom_range(0, 2), 0);
    goto_memory(7'b0000011);
    @(negedge stage_clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({mif.imem_req, mif.dmem_req, mif.dmem_we, ir_en, pc_en, save_to_reg, save_from_memory,
         halt, fault, fault_cause} !== 11'd0 || retired_count !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid: dmem_req=%b sfm=%b s2r=%b retired=%0d, expected all 0",
               mif.dmem_req, save_from_memory, save_to_reg, retired_count);
    end
    repeat (2) @(posedge stage_clk);
    @(negedge stage_clk);
    reset = 1'b0;
    #1;
    checks++;
    if (mif.imem_req !== 1'b0 || retired_count !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_wait: imem_req=%b retired=%0d, expected 0 and 0", mif.imem_req, retired_count);
    end
    @(posedge stage_clk);
    #1;
    checks++;
    if (mif.imem_req !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_mid_fetch: imem_req=%b, expected 1", mif.imem_req);
    end
    exp_retired = 32'd0;
    run_instr(7'b0100011, 0, 1);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_retired = 32'd0;
    test_reset();
    test_directed();
    test_random();
    test_stop_states();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
